// File: rtl/riscv_apu_disp_pkg.sv
// Shared types and helpers for the APU dispatcher and its in-order result queue.
package riscv_apu_disp_pkg;

  typedef enum logic [1:0] {
    LAT_SINGLE0 = 2'd0,
    LAT_SINGLE1 = 2'd1,
    LAT_PIPE    = 2'd2,
    LAT_MULTI   = 2'd3
  } lat_e;

  localparam int DEPTH_DEFAULT = 4;

  // Pointer width for a power-of-two queue depth; pointers wrap naturally.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/riscv_apu_disp_fifo.sv
// In-order address queue for outstanding APU ops; exports every slot and its
// occupancy so the dispatcher can run hazard compares against all entries.
module riscv_apu_disp_fifo
  import riscv_apu_disp_pkg::*;
#(
  parameter  int DEPTH  = DEPTH_DEFAULT,
  parameter  int ADDR_W = 6,
  localparam int PW     = ptr_w(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [ADDR_W-1:0]             push_addr_i,
  output logic [ADDR_W-1:0]             head_addr,
  output logic [PW-1:0]                 head_idx,
  output logic [CNT_W-1:0]              count,
  output logic [DEPTH-1:0][ADDR_W-1:0]  entry_addr,
  output logic [DEPTH-1:0]              entry_valid
);

  logic [DEPTH-1:0][ADDR_W-1:0] mem_q;
  logic [PW-1:0]                rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]             count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: stale slots are masked by entry_valid.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_addr_i;
  end

  always_comb begin
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] off;
      off            = PW'(i) - rd_ptr_q;
      entry_valid[i] = CNT_W'(off) < count_q;
    end
  end

  assign head_addr  = mem_q[rd_ptr_q];
  assign head_idx   = rd_ptr_q;
  assign count      = count_q;
  assign entry_addr = mem_q;

endmodule

// File: rtl/riscv_apu_disp_q.sv
// APU dispatcher with a DEPTH-deep in-order result queue, hazard detection and
// a sticky protocol error. Optional counters are enabled by APU_DISP_PERF_EN.
module riscv_apu_disp_q
  import riscv_apu_disp_pkg::*;
#(
  parameter  int DEPTH  = DEPTH_DEFAULT,
  parameter  int ADDR_W = 6,
  parameter  int N_RD   = 3,
  parameter  int N_WR   = 2,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic [1:0]               apu_lat_i,
  input  logic [ADDR_W-1:0]        apu_waddr_i,
  output logic [ADDR_W-1:0]        apu_waddr_o,
  output logic                     apu_multicycle_o,
  output logic                     apu_singlecycle_o,
  output logic                     active_o,
  output logic                     stall_o,
  input  logic [N_RD*ADDR_W-1:0]   read_regs_i,
  input  logic [N_RD-1:0]          read_regs_valid_i,
  output logic                     read_dep_o,
  input  logic [N_WR*ADDR_W-1:0]   write_regs_i,
  input  logic [N_WR-1:0]          write_regs_valid_i,
  output logic                     write_dep_o,
  output logic                     perf_type_o,
  output logic                     perf_cont_o,
  output logic                     apu_master_req_o,
  output logic                     apu_master_ready_o,
  input  logic                     apu_master_gnt_i,
  input  logic                     apu_master_valid_i,
  output logic                     err_o,
  output logic [31:0]              type_cnt_o,
  output logic [31:0]              cont_cnt_o,
  output logic [CNT_W-1:0]         occ_max_o
);

  localparam int PW = ptr_w(DEPTH);

  logic [ADDR_W-1:0]            head_addr;
  logic [PW-1:0]                head_idx;
  logic [CNT_W-1:0]             count;
  logic [DEPTH-1:0][ADDR_W-1:0] entry_addr;
  logic [DEPTH-1:0]             entry_valid;

  lat_e last_lat_q;
  lat_e lat;
  logic err_q;
  logic active, stall_full, stall_type, stall_nack;
  logic valid_req, accepted, same_cycle_return, pop, push;

  // Handshake: a request is held on apu_master_req_o while valid_req is high
  // and counts as accepted only in a cycle where apu_master_gnt_i is also high;
  // results return in issue order, one per cycle in which apu_master_valid_i is high.
  assign lat        = lat_e'(apu_lat_i);
  assign active     = (count != '0);
  assign stall_full = (count == CNT_W'(DEPTH));
  assign stall_type = enable_i & active &
                      ((lat == LAT_SINGLE1) | (lat == LAT_MULTI) |
                       ((lat == LAT_PIPE) & (last_lat_q == LAT_MULTI)));
  assign valid_req  = enable_i & ~stall_full & ~stall_type;
  assign stall_nack = valid_req & ~apu_master_gnt_i;
  assign accepted   = valid_req & apu_master_gnt_i;

  assign same_cycle_return = ~active & apu_master_valid_i & valid_req;
  assign pop               = active & apu_master_valid_i;
  assign push              = accepted & ~same_cycle_return;

  riscv_apu_disp_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .pop_i       (pop),
    .push_addr_i (apu_waddr_i),
    .head_addr   (head_addr),
    .head_idx    (head_idx),
    .count       (count),
    .entry_addr  (entry_addr),
    .entry_valid (entry_valid)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_lat_q <= LAT_SINGLE0;
      err_q      <= 1'b0;
    end else begin
      if (accepted) last_lat_q <= lat;
      if (apu_master_valid_i & ~active & ~valid_req) err_q <= 1'b1;
    end
  end

  always_comb begin
    apu_waddr_o = '0;
    if (same_cycle_return) apu_waddr_o = apu_waddr_i;
    else if (pop)          apu_waddr_o = head_addr;
  end

  // An entry retiring this cycle no longer blocks; a request being issued does.
  always_comb begin
    logic req_live;
    read_dep_o  = 1'b0;
    write_dep_o = 1'b0;
    req_live    = valid_req & ~same_cycle_return;
    for (int e = 0; e < DEPTH; e++) begin
      logic live;
      live = entry_valid[e] & ~((PW'(e) == head_idx) & pop);
      for (int r = 0; r < N_RD; r++)
        if (live & read_regs_valid_i[r] & (read_regs_i[r*ADDR_W +: ADDR_W] == entry_addr[e]))
          read_dep_o = 1'b1;
      for (int w = 0; w < N_WR; w++)
        if (live & write_regs_valid_i[w] & (write_regs_i[w*ADDR_W +: ADDR_W] == entry_addr[e]))
          write_dep_o = 1'b1;
    end
    for (int r = 0; r < N_RD; r++)
      if (req_live & read_regs_valid_i[r] & (read_regs_i[r*ADDR_W +: ADDR_W] == apu_waddr_i))
        read_dep_o = 1'b1;
    for (int w = 0; w < N_WR; w++)
      if (req_live & write_regs_valid_i[w] & (write_regs_i[w*ADDR_W +: ADDR_W] == apu_waddr_i))
        write_dep_o = 1'b1;
  end

  assign apu_multicycle_o   = (last_lat_q == LAT_MULTI);
  assign apu_singlecycle_o  = ~active;
  assign active_o           = active;
  assign stall_o            = stall_full | stall_type | stall_nack;
  assign perf_type_o        = stall_type;
  assign perf_cont_o        = stall_nack;
  assign apu_master_req_o   = valid_req;
  assign apu_master_ready_o = 1'b1;
  assign err_o              = err_q;

`ifdef APU_DISP_PERF_EN
  logic [31:0]      type_cnt_q, cont_cnt_q;
  logic [CNT_W-1:0] occ_max_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      type_cnt_q <= '0;
      cont_cnt_q <= '0;
      occ_max_q  <= '0;
    end else begin
      if (stall_type & ~&type_cnt_q) type_cnt_q <= type_cnt_q + 1'b1;
      if (stall_nack & ~&cont_cnt_q) cont_cnt_q <= cont_cnt_q + 1'b1;
      if (count > occ_max_q)         occ_max_q  <= count;
    end
  end

  assign type_cnt_o = type_cnt_q;
  assign cont_cnt_o = cont_cnt_q;
  assign occ_max_o  = occ_max_q;
`else
  assign type_cnt_o = '0;
  assign cont_cnt_o = '0;
  assign occ_max_o  = '0;
`endif

endmodule

// File: tb/tb_riscv_apu_disp_q.sv
// Directed bench for riscv_apu_disp_q: issue, queue-full, same-cycle return,
// type stall with hazards, grant back-pressure, sticky error and reset.
module tb_riscv_apu_disp_q;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 6;
  localparam int N_RD   = 3;
  localparam int N_WR   = 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   enable_i;
  logic [1:0]             apu_lat_i;
  logic [ADDR_W-1:0]      apu_waddr_i;
  logic [ADDR_W-1:0]      apu_waddr_o;
  logic                   apu_multicycle_o, apu_singlecycle_o, active_o, stall_o;
  logic [N_RD*ADDR_W-1:0] read_regs_i;
  logic [N_RD-1:0]        read_regs_valid_i;
  logic                   read_dep_o;
  logic [N_WR*ADDR_W-1:0] write_regs_i;
  logic [N_WR-1:0]        write_regs_valid_i;
  logic                   write_dep_o, perf_type_o, perf_cont_o;
  logic                   apu_master_req_o, apu_master_ready_o;
  logic                   apu_master_gnt_i, apu_master_valid_i, err_o;
  logic [31:0]            type_cnt_o, cont_cnt_o;
  logic [CNT_W-1:0]       occ_max_o;

  int pass_cnt = 0;
  int total    = 0;
  logic [ADDR_W-1:0] exp_q[$];

  riscv_apu_disp_q #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .N_RD(N_RD), .N_WR(N_WR)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .enable_i           (enable_i),
    .apu_lat_i          (apu_lat_i),
    .apu_waddr_i        (apu_waddr_i),
    .apu_waddr_o        (apu_waddr_o),
    .apu_multicycle_o   (apu_multicycle_o),
    .apu_singlecycle_o  (apu_singlecycle_o),
    .active_o           (active_o),
    .stall_o            (stall_o),
    .read_regs_i        (read_regs_i),
    .read_regs_valid_i  (read_regs_valid_i),
    .read_dep_o         (read_dep_o),
    .write_regs_i       (write_regs_i),
    .write_regs_valid_i (write_regs_valid_i),
    .write_dep_o        (write_dep_o),
    .perf_type_o        (perf_type_o),
    .perf_cont_o        (perf_cont_o),
    .apu_master_req_o   (apu_master_req_o),
    .apu_master_ready_o (apu_master_ready_o),
    .apu_master_gnt_i   (apu_master_gnt_i),
    .apu_master_valid_i (apu_master_valid_i),
    .err_o              (err_o),
    .type_cnt_o         (type_cnt_o),
    .cont_cnt_o         (cont_cnt_o),
    .occ_max_o          (occ_max_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_req(input logic en, input logic [1:0] lat,
                           input logic [ADDR_W-1:0] addr, input logic gnt);
    enable_i         = en;
    apu_lat_i        = lat;
    apu_waddr_i      = addr;
    apu_master_gnt_i = gnt;
  endtask

  task automatic idle();
    drive_req(1'b0, 2'd0, '0, 1'b0);
    apu_master_valid_i = 1'b0;
    read_regs_i        = '0;
    read_regs_valid_i  = '0;
    write_regs_i       = '0;
    write_regs_valid_i = '0;
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    #12;
    chk("rst_stall", stall_o, 0);
    chk("rst_active", active_o, 0);
    chk("rst_single", apu_singlecycle_o, 1);
    chk("rst_waddr", apu_waddr_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_multi", apu_multicycle_o, 0);
    chk("ready", apu_master_ready_o, 1);
    rst_i = 1'b0;
    tick();

    // 1: single multicycle op round trip
    drive_req(1'b1, 2'd3, 6'd5, 1'b1);
    #1 chk("t1_req", apu_master_req_o, 1);
    tick();
    idle();
    #1 chk("t1_active", active_o, 1);
    chk("t1_multi", apu_multicycle_o, 1);
    chk("t1_single", apu_singlecycle_o, 0);
    tick();
    tick();
    apu_master_valid_i = 1'b1;
    #1 chk("t1_waddr", apu_waddr_o, 5);
    tick();
    idle();
    #1 chk("t1_drained", active_o, 0);

    // 2: fill to DEPTH, full stall, pop releases on the following cycle
    for (int i = 1; i <= DEPTH; i++) begin
      drive_req(1'b1, 2'd2, ADDR_W'(i), 1'b1);
      exp_q.push_back(ADDR_W'(i));
      tick();
    end
    drive_req(1'b1, 2'd2, 6'd5, 1'b1);
    #1 chk("t2_full_stall", stall_o, 1);
    chk("t2_full_req", apu_master_req_o, 0);
    chk("t2_no_type", perf_type_o, 0);
    apu_master_valid_i = 1'b1;
    #1 chk("t2_pop_waddr", apu_waddr_o, exp_q.pop_front());
    chk("t2_stall_held", stall_o, 1);
    tick();
    apu_master_valid_i = 1'b0;
    #1 chk("t2_released", stall_o, 0);
    chk("t2_req_again", apu_master_req_o, 1);
    exp_q.push_back(6'd5);
    tick();
    idle();
    apu_master_valid_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1 chk("t2_order", apu_waddr_o, exp_q.pop_front());
      tick();
    end
    apu_master_valid_i = 1'b0;
    #1 chk("t2_empty", active_o, 0);
    chk("t2_err", err_o, 0);

    // 3: same-cycle return leaves the queue empty
    drive_req(1'b1, 2'd0, 6'd9, 1'b1);
    apu_master_valid_i = 1'b1;
    #1 chk("t3_waddr", apu_waddr_o, 9);
    tick();
    idle();
    #1 chk("t3_active", active_o, 0);
    chk("t3_err", err_o, 0);

    // 4: type stall behind a multicycle op, hazards, and release on pop
    drive_req(1'b1, 2'd3, 6'd7, 1'b1);
    tick();
    drive_req(1'b1, 2'd1, 6'd8, 1'b1);
    read_regs_i        = {6'd0, 6'd0, 6'd7};
    read_regs_valid_i  = 3'b001;
    write_regs_i       = {6'd7, 6'd3};
    write_regs_valid_i = 2'b10;
    #1 chk("t4_type", perf_type_o, 1);
    chk("t4_stall", stall_o, 1);
    chk("t4_req", apu_master_req_o, 0);
    chk("t4_rdep", read_dep_o, 1);
    chk("t4_wdep", write_dep_o, 1);
    apu_master_valid_i = 1'b1;
    #1 chk("t4_pop_waddr", apu_waddr_o, 7);
    chk("t4_rdep_pop", read_dep_o, 0);
    chk("t4_wdep_pop", write_dep_o, 0);
    tick();
    idle();

    // 5: grant back-pressure, then accept
    drive_req(1'b1, 2'd2, 6'd10, 1'b0);
    read_regs_i       = {6'd10, 6'd0, 6'd0};
    read_regs_valid_i = 3'b100;
    #1 chk("t5_nack", perf_cont_o, 1);
    chk("t5_stall", stall_o, 1);
    chk("t5_req", apu_master_req_o, 1);
    chk("t5_req_dep", read_dep_o, 1);
    tick();
    chk("t5_not_queued", active_o, 0);
    apu_master_gnt_i = 1'b1;
    #1 chk("t5_no_nack", perf_cont_o, 0);
    tick();
    idle();
    #1 chk("t5_queued", active_o, 1);
    apu_master_valid_i = 1'b1;
    #1 chk("t5_waddr", apu_waddr_o, 10);
    tick();
    idle();
`ifdef APU_DISP_PERF_EN
    chk("occ_max", occ_max_o, DEPTH);
`else
    chk("perf_tied", {type_cnt_o[15:0], cont_cnt_o[12:0], occ_max_o}, 0);
`endif

    // 6: sticky error, then reset mid-queue
    apu_master_valid_i = 1'b1;
    #1 chk("t6_err_pre", err_o, 0);
    tick();
    apu_master_valid_i = 1'b0;
    #1 chk("t6_err_set", err_o, 1);
    tick();
    chk("t6_err_sticky", err_o, 1);
    for (int i = 1; i <= 3; i++) begin
      drive_req(1'b1, 2'd2, ADDR_W'(i + 20), 1'b1);
      tick();
    end
    idle();
    #1 chk("t6_active", active_o, 1);
    rst_i = 1'b1;
    #1 chk("t6_rst_active", active_o, 0);
    chk("t6_rst_err", err_o, 0);
    chk("t6_rst_single", apu_singlecycle_o, 1);
    tick();
    rst_i = 1'b0;
    apu_master_valid_i = 1'b1;
    tick();
    apu_master_valid_i = 1'b0;
    #1 chk("t6_err_after_rst", err_o, 1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
